uart_receiver: RTL and testbench

Serial receive counterpart of the team's UART byte sender. Takes the asynchronous RX line, synchronises it to `clock`, detects a start bit, samples 8 data bits LSB first at mid-bit, and checks the stop bit. Each good byte goes into a one-entry holding register, signalled by a level `data_ready` and released by a `read_ack` handshake. Sits between the board RX pin and the game/command logic, mirroring the sender on TX.

---
 rtl/uart_receiver.sv | 162 ++++++++++++++++
 tb/tb_uart_receiver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronised RX, mid-bit sampling, 8N1 framing, one-entry holding register.
// Define UART_RX_MAJORITY_EN to sample each bit by 2-of-3 majority of the synchronised line.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int clock_per_bit      = 2604,
  parameter int half_clock_per_bit = 1302
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in,
  input  logic       read_ack,
  output logic [7:0] received,
  output logic       data_ready,
  output logic       busy,
  output logic       frame_error,
  output logic       overrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  localparam logic [11:0] BIT_LAST  = 12'(clock_per_bit - 1);
  localparam logic [11:0] HALF_LAST = 12'(half_clock_per_bit - 1);

  state_t      state_q, state_d;
  logic        sync1_q, rx_s_q;
  logic [11:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  received_q, received_d;
  logic        data_ready_q, data_ready_d;
  logic        busy_q, busy_d;
  logic        frame_error_q, frame_error_d;
  logic        overrun_q, overrun_d;
  logic        sample;
  logic        ack;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= in;
      rx_s_q  <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) hist_q <= 2'b11;
    else          hist_q <= {hist_q[0], rx_s_q};
  end

  assign sample = (rx_s_q & hist_q[0]) | (rx_s_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rx_s_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      received_q    <= '0;
      data_ready_q  <= 1'b0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      received_q    <= received_d;
      data_ready_q  <= data_ready_d;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q + 12'd1;
    idx_d         = idx_q;
    shift_d       = shift_q;
    received_d    = received_q;
    data_ready_d  = data_ready_q;
    overrun_d     = overrun_q;
    frame_error_d = 1'b0;
    ack           = read_ack && data_ready_q;

    // A consumer ack releases the holder; a load in the same cycle overrides below.
    if (ack) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          if (!sample) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          shift_d   = {sample, shift_q[7:1]};
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (sample) begin
            state_d = IDLE;
            if (!data_ready_q || read_ack) begin
              received_d   = shift_q;
              data_ready_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_error_d = 1'b1;
            state_d       = BREAK;
          end
        end
      end
      BREAK: begin
        // A line stuck low must return high before a new frame can start.
        bit_cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        bit_cnt_d = '0;
        state_d   = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign received    = received_q;
  assign data_ready  = data_ready_q;
  assign busy        = busy_q;
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised self-checking bench for uart_receiver with a small holding-register model.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CPB    = 16;
  localparam int HALF   = 8;
  localparam int FRAME  = 10 * CPB;
  localparam int STOP_C = 2 + 1 + HALF + 9 * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in = 1'b1;
  logic       read_ack = 1'b0;
  logic [7:0] received;
  logic       data_ready, busy, frame_error, overrun;

  int checks = 0;
  int errors = 0;

  logic       tr_dr   [0:FRAME];
  logic       tr_fe   [0:FRAME];
  logic       tr_busy [0:FRAME];
  logic       tr_ov   [0:FRAME];
  logic [7:0] tr_rx   [0:FRAME];

  uart_receiver #(.clock_per_bit(CPB), .half_clock_per_bit(HALF)) dut (
    .clock(clock), .reset_n(reset_n), .in(in), .read_ack(read_ack),
    .received(received), .data_ready(data_ready), .busy(busy),
    .frame_error(frame_error), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives one frame; trace index c holds outputs just after the c-th edge following the falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ack_c, input int glitch_c);
    logic [9:0] bits;
    logic       line;
    bits = {stop_bit, b, 1'b0};
    in = 1'b0;
    for (int c = 1; c <= FRAME; c++) begin
      tick();
      tr_dr[c] = data_ready; tr_fe[c] = frame_error; tr_busy[c] = busy;
      tr_ov[c] = overrun;    tr_rx[c] = received;
      read_ack = (c == ack_c);
      line = (c / CPB >= 9) ? stop_bit : bits[c / CPB];
      if (c == glitch_c) line = ~line;
      in = line;
    end
    read_ack = 1'b0;
  endtask

  function automatic int count_fe();
    int n = 0;
    for (int c = 1; c <= FRAME; c++) n += (tr_fe[c] === 1'b1) ? 1 : 0;
    return n;
  endfunction

  task automatic do_ack();
    read_ack = 1'b1;
    tick();
    read_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in = 1'b1;
    repeat (3) tick();
    checks++; if (received !== 8'h00) begin errors++; $display("FAIL reset_received got %h want 00", received); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got %b want 0", data_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, -1, -1);
    checks++; if (tr_dr[STOP_C-1] !== 1'b0) begin errors++; $display("FAIL basic_ready_early got %b want 0", tr_dr[STOP_C-1]); end
    checks++; if (tr_dr[STOP_C] !== 1'b1) begin errors++; $display("FAIL basic_ready_on_time got %b want 1", tr_dr[STOP_C]); end
    checks++; if (tr_rx[STOP_C] !== 8'hA5) begin errors++; $display("FAIL basic_received got %h want a5", tr_rx[STOP_C]); end
    checks++; if (tr_ov[FRAME] !== 1'b0) begin errors++; $display("FAIL basic_overrun got %b want 0", tr_ov[FRAME]); end
    checks++; if (count_fe() != 0) begin errors++; $display("FAIL basic_frame_error got %0d pulses want 0", count_fe()); end
    checks++; if (tr_busy[1] !== 1'b0) begin errors++; $display("FAIL basic_busy_before got %b want 0", tr_busy[1]); end
    checks++; if (tr_busy[40] !== 1'b1) begin errors++; $display("FAIL basic_busy_mid got %b want 1", tr_busy[40]); end
    checks++; if (tr_busy[STOP_C+3] !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", tr_busy[STOP_C+3]); end
    do_ack();
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL basic_ack_clear got %b want 0", data_ready); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h3C, 1'b1, -1, -1);
    checks++; if (tr_rx[STOP_C] !== 8'h3C || tr_dr[STOP_C] !== 1'b1) begin errors++; $display("FAIL b2b_first got %h/%b want 3c/1", tr_rx[STOP_C], tr_dr[STOP_C]); end
    send_frame(8'hC3, 1'b1, 20, -1);
    checks++; if (tr_dr[30] !== 1'b0) begin errors++; $display("FAIL b2b_ack got %b want 0", tr_dr[30]); end
    checks++; if (tr_rx[STOP_C] !== 8'hC3 || tr_dr[STOP_C] !== 1'b1) begin errors++; $display("FAIL b2b_second got %h/%b want c3/1", tr_rx[STOP_C], tr_dr[STOP_C]); end
    checks++; if (tr_ov[FRAME] !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", tr_ov[FRAME]); end
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, -1, -1);
    send_frame(8'h22, 1'b1, -1, -1);
    checks++; if (tr_ov[STOP_C-1] !== 1'b0 || tr_ov[STOP_C] !== 1'b1) begin errors++; $display("FAIL ovr_set got %b%b want 01", tr_ov[STOP_C-1], tr_ov[STOP_C]); end
    checks++; if (tr_rx[FRAME] !== 8'h11 || tr_dr[FRAME] !== 1'b1) begin errors++; $display("FAIL ovr_kept got %h/%b want 11/1", tr_rx[FRAME], tr_dr[FRAME]); end
    do_ack();
    checks++; if (data_ready !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear got %b%b want 00", data_ready, overrun); end
    send_frame(8'h44, 1'b1, -1, -1);
    send_frame(8'h55, 1'b1, -1, -1);
    send_frame(8'h66, 1'b1, STOP_C - 1, -1);
    checks++; if (tr_ov[STOP_C-1] !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", tr_ov[STOP_C-1]); end
    checks++; if (tr_rx[STOP_C] !== 8'h66 || tr_dr[STOP_C] !== 1'b1 || tr_ov[STOP_C] !== 1'b0) begin
      errors++; $display("FAIL load_wins got %h/%b/%b want 66/1/0", tr_rx[STOP_C], tr_dr[STOP_C], tr_ov[STOP_C]);
    end
    do_ack();
  endtask

  task automatic test_frame_error();
    int fe_n = 0;
    int dr_n = 0;
    send_frame(8'h5A, 1'b0, -1, -1);
    checks++; if (tr_fe[STOP_C] !== 1'b1 || count_fe() != 1) begin errors++; $display("FAIL fe_pulse got %b/%0d want 1/1", tr_fe[STOP_C], count_fe()); end
    checks++; if (tr_dr[FRAME] !== 1'b0) begin errors++; $display("FAIL fe_ready got %b want 0", tr_dr[FRAME]); end
    repeat (40) begin
      tick();
      fe_n += (frame_error === 1'b1) ? 1 : 0;
    end
    checks++; if (busy !== 1'b1 || fe_n != 0) begin errors++; $display("FAIL fe_hold got busy %b pulses %0d want 1/0", busy, fe_n); end
    in = 1'b1;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fe_release_busy got %b want 0", busy); end
    repeat (200) begin
      tick();
      fe_n += (frame_error === 1'b1) ? 1 : 0;
      dr_n += (data_ready === 1'b1) ? 1 : 0;
    end
    checks++; if (fe_n != 0 || dr_n != 0) begin errors++; $display("FAIL fe_spurious got fe %0d ready %0d want 0/0", fe_n, dr_n); end
  endtask

  task automatic test_false_start();
    logic b6, b20;
    int   dr_n = 0;
    int   fe_n = 0;
    b6 = 1'b0; b20 = 1'b1;
    in = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c == 6)  b6  = busy;
      if (c == 20) b20 = busy;
      if (c == 4)  in  = 1'b1;
      dr_n += (data_ready === 1'b1) ? 1 : 0;
      fe_n += (frame_error === 1'b1) ? 1 : 0;
    end
    checks++; if (b6 !== 1'b1) begin errors++; $display("FAIL false_start_busy got %b want 1", b6); end
    checks++; if (b20 !== 1'b0) begin errors++; $display("FAIL false_start_idle got %b want 0", b20); end
    checks++; if (dr_n != 0 || fe_n != 0) begin errors++; $display("FAIL false_start_output got ready %0d fe %0d want 0/0", dr_n, fe_n); end
  endtask

  task automatic test_reset_mid();
    int dr_n = 0;
    send_frame(8'h77, 1'b1, -1, -1);
    in = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      in = (c >= CPB) ? 1'b1 : 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({received, data_ready, busy, frame_error, overrun} !== 12'h000) begin
      errors++; $display("FAIL async_reset got %h %b%b%b%b want 00 0000", received, data_ready, busy, frame_error, overrun);
    end
    tick();
    reset_n = 1'b1;
    repeat (150) begin
      tick();
      dr_n += (data_ready === 1'b1) ? 1 : 0;
    end
    checks++; if (dr_n != 0 || busy !== 1'b0) begin errors++; $display("FAIL reset_partial got ready %0d busy %b want 0/0", dr_n, busy); end
    send_frame(8'h81, 1'b1, -1, -1);
    checks++; if (tr_rx[STOP_C] !== 8'h81 || tr_dr[STOP_C] !== 1'b1 || tr_dr[STOP_C-1] !== 1'b0) begin
      errors++; $display("FAIL reset_recover got %h/%b want 81/1", tr_rx[STOP_C], tr_dr[STOP_C]);
    end
    do_ack();
  endtask

  task automatic test_random();
    logic [7:0] m_rx, b;
    logic       m_ready, m_ov, bad, pre_ready;
    m_rx = 8'h00; m_ready = 1'b0; m_ov = 1'b0;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      pre_ready = m_ready;
      send_frame(b, ~bad, -1, -1);
      if (bad) begin
        checks++; if (tr_fe[STOP_C] !== 1'b1 || count_fe() != 1) begin errors++; $display("FAIL rand_fe[%0d] got %b/%0d want 1/1", i, tr_fe[STOP_C], count_fe()); end
        in = 1'b1;
        repeat (4) tick();
      end else begin
        checks++; if (count_fe() != 0) begin errors++; $display("FAIL rand_no_fe[%0d] got %0d want 0", i, count_fe()); end
        if (m_ready) m_ov = 1'b1;
        else begin m_rx = b; m_ready = 1'b1; end
        if (!pre_ready) begin
          checks++; if (tr_dr[STOP_C-1] !== 1'b0 || tr_dr[STOP_C] !== 1'b1) begin errors++; $display("FAIL rand_timing[%0d] got %b%b want 01", i, tr_dr[STOP_C-1], tr_dr[STOP_C]); end
        end
      end
      checks++; if (data_ready !== m_ready || overrun !== m_ov) begin errors++; $display("FAIL rand_flags[%0d] got %b%b want %b%b", i, data_ready, overrun, m_ready, m_ov); end
      if (m_ready) begin
        checks++; if (received !== m_rx) begin errors++; $display("FAIL rand_byte[%0d] got %h want %h", i, received, m_rx); end
      end
      if ($urandom_range(0, 1) == 1) begin
        do_ack();
        if (m_ready) begin m_ready = 1'b0; m_ov = 1'b0; end
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_busy_end got %b want 0", busy); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    send_frame(8'h55, 1'b1, -1, 4 * CPB + 8);
    checks++; if (tr_rx[STOP_C] !== 8'h55 || tr_dr[STOP_C] !== 1'b1) begin errors++; $display("FAIL majority_glitch got %h want 55", tr_rx[STOP_C]); end
    do_ack();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_frame_error();
    test_false_start();
    test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
